freq_monitor: RTL and testbench

- Synthesizable multi-channel clock-frequency monitor for on-chip PLL/DCO bring-up.
- Counts rising edges of NUM_CH slow monitored signals over a programmable gate window of `clock` cycles. Typical inputs are divided core and user clocks.
- Checks each count against a per-run min/max band and reports pass/fail per channel.
- Lets firmware run the PLL characterisation sequence (disabled, bypass, min, max, DCO) without an external bench.

---
 rtl/freq_mon_pkg.sv | 26 ++
 rtl/freq_mon_chan.sv | 50 +++++
 rtl/freq_monitor.sv | 121 ++++++++++++
 tb/tb_freq_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_mon_pkg.sv
// Shared FSM encoding, default widths and the channel-ratio helper for freq_monitor.
package freq_mon_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        GATE = 3'd2,
        EVAL = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_WIN_W     = 20;
    localparam int DEF_TOL_SHIFT = 5;

    // True when cnt lies within (ref_cnt >> shift) of ref_cnt.
    function automatic logic ratio_ok(input logic [31:0] cnt,
                                      input logic [31:0] ref_cnt,
                                      input int          shift);
        logic [31:0] diff;
        diff = (cnt > ref_cnt) ? (cnt - ref_cnt) : (ref_cnt - cnt);
        return diff <= (ref_cnt >> shift);
    endfunction

endpackage

// File: rtl/freq_mon_chan.sv
// One monitored input: 2-flop synchronizer, registered rise detect, saturating edge counter.
// An input rise reaches the counter 3 cycles later; clr wins over en.
module freq_mon_chan
    import freq_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             mon,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic sync1, sync2, prev, rise;

    // The synchronizer runs continuously so opening the gate never fabricates an edge.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= mon;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en && rise) begin
            if (&cnt) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/freq_monitor.sv
// Multi-channel frequency monitor: counts mon_in edges over a gate window, checks a min/max band (+ratio check with FREQ_MON_RATIO_CHECK_EN).
// Latency start->done = window_len + 3 cycles; no backpressure, start while busy or in DONE is ignored.
module freq_monitor
    import freq_mon_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WIN_W     = DEF_WIN_W,
    parameter int TOL_SHIFT = DEF_TOL_SHIFT
) (
    input  logic                    clock,
    input  logic                    resetb,
    input  logic [NUM_CH-1:0]       mon_in,
    input  logic                    start,
    input  logic [WIN_W-1:0]        window_len,
    input  logic [CNT_W-1:0]        min_cnt,
    input  logic [CNT_W-1:0]        max_cnt,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH*CNT_W-1:0] counts,
    output logic [NUM_CH-1:0]       pass,
    output logic [NUM_CH-1:0]       ovf
);

    if (NUM_CH < 1 || NUM_CH > 8 || TOL_SHIFT < 0) begin : g_param_err
        $error("freq_monitor: parameter out of range");
    end

    state_t            state;
    logic [WIN_W-1:0]  win_len_q;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  min_q;
    logic [CNT_W-1:0]  max_q;
    logic              clr;
    logic              en;
    logic [NUM_CH-1:0] pass_next;

    assign clr = (state == IDLE) && start;
    assign en  = (state == GATE);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        freq_mon_chan #(.CNT_W(CNT_W)) u_chan (
            .clock  (clock),
            .resetb (resetb),
            .mon    (mon_in[i]),
            .clr    (clr),
            .en     (en),
            .cnt    (counts[i*CNT_W +: CNT_W]),
            .ovf    (ovf[i])
        );
    end

    always_comb begin
        logic [CNT_W-1:0] c;
        logic             ok;
        pass_next = '0;
        c         = '0;
        ok        = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            c  = counts[i*CNT_W +: CNT_W];
            ok = (min_q <= c) && (c <= max_q) && !ovf[i];
`ifdef FREQ_MON_RATIO_CHECK_EN
            if (i > 0) begin
                ok = ok && ratio_ok(32'(c), 32'(counts[CNT_W-1:0]), TOL_SHIFT);
            end
`endif
            pass_next[i] = ok;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= '0;
            win_len_q <= '0;
            win_cnt   <= '0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_len_q <= window_len;
                        min_q     <= min_cnt;
                        max_q     <= max_cnt;
                        pass      <= '0;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    win_cnt <= win_len_q;
                    state   <= (win_len_q == '0) ? EVAL : GATE;
                end
                // Gate stays open for exactly win_len_q cycles, last cycle included.
                GATE: begin
                    win_cnt <= win_cnt - 1'b1;
                    if (win_cnt == WIN_W'(1)) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    pass  <= pass_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_monitor.sv
// Directed bench for freq_monitor: vector table on a default instance, hand sequences for restart, reset and saturation.
module tb_freq_monitor;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] mon_a = 2'b00;
    logic       mon_b = 1'b0;
    always #100 mon_a[0] = ~mon_a[0];
    always #200 mon_a[1] = ~mon_a[1];
    always #20  mon_b    = ~mon_b;

    logic        start_a = 1'b0;
    logic [19:0] window_a = '0;
    logic [15:0] min_a = '0, max_a = '0;
    logic        busy_a, done_a;
    logic [31:0] counts_a;
    logic [1:0]  pass_a, ovf_a;

    logic        start_b = 1'b0;
    logic [19:0] window_b = '0;
    logic [3:0]  min_b = '0, max_b = '0;
    logic        busy_b, done_b;
    logic [7:0]  counts_b;
    logic [1:0]  pass_b, ovf_b;

    freq_monitor u_dut_a (
        .clock(clock), .resetb(resetb), .mon_in(mon_a), .start(start_a),
        .window_len(window_a), .min_cnt(min_a), .max_cnt(max_a),
        .busy(busy_a), .done(done_a), .counts(counts_a), .pass(pass_a), .ovf(ovf_a)
    );

    freq_monitor #(.CNT_W(4)) u_dut_b (
        .clock(clock), .resetb(resetb), .mon_in({mon_b, mon_b}), .start(start_b),
        .window_len(window_b), .min_cnt(min_b), .max_cnt(max_b),
        .busy(busy_b), .done(done_b), .counts(counts_b), .pass(pass_b), .ovf(ovf_b)
    );

`ifdef FREQ_MON_RATIO_CHECK_EN
    localparam logic [1:0] RP = 2'b01;
`else
    localparam logic [1:0] RP = 2'b11;
`endif

    typedef struct {
        int         win;
        int         mn;
        int         mx;
        logic [1:0] pass;
        int         c0lo, c0hi, c1lo, c1hi;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done_a = 0;

    always @(negedge clock) if (done_a === 1'b1) n_done_a++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input logic [63:0] act, input int lo, input int hi);
        n_chk++;
        if ($isunknown(act) || act < 64'(lo) || act > 64'(hi)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic run_a(input vec_t v, input string tag);
        int lat;
        @(negedge clock);
        window_a = 20'(v.win); min_a = 16'(v.mn); max_a = 16'(v.mx); start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        lat = 1;
        check({tag, ".busy_arm"}, 64'(busy_a), 64'd1);
        while (done_a !== 1'b1 && lat < v.win + 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(v.win + 3));
        check({tag, ".busy_at_done"}, 64'(busy_a), 64'd0);
        check_rng({tag, ".cnt0"}, 64'(counts_a[15:0]), v.c0lo, v.c0hi);
        check_rng({tag, ".cnt1"}, 64'(counts_a[31:16]), v.c1lo, v.c1hi);
        check({tag, ".pass"}, 64'(pass_a), 64'(v.pass));
        check({tag, ".ovf"}, 64'(ovf_a), 64'd0);
        @(negedge clock);
        check({tag, ".done_pulse"}, 64'(done_a), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        int   d0;
        vecs[0] = '{win: 1000, mn: 20, mx: 60, pass: RP,    c0lo: 49, c0hi: 51, c1lo: 24, c1hi: 26};
        vecs[1] = '{win: 1000, mn: 30, mx: 60, pass: 2'b01, c0lo: 49, c0hi: 51, c1lo: 24, c1hi: 26};
        vecs[2] = '{win: 0,    mn: 0,  mx: 60, pass: 2'b11, c0lo: 0,  c0hi: 0,  c1lo: 0,  c1hi: 0};
        vecs[3] = '{win: 0,    mn: 1,  mx: 60, pass: 2'b00, c0lo: 0,  c0hi: 0,  c1lo: 0,  c1hi: 0};
        vecs[4] = '{win: 100,  mn: 5,  mx: 4,  pass: 2'b00, c0lo: 4,  c0hi: 6,  c1lo: 2,  c1hi: 3};
        vecs[5] = '{win: 100,  mn: 2,  mx: 6,  pass: RP,    c0lo: 4,  c0hi: 6,  c1lo: 2,  c1hi: 3};

        #12;
        check("rst.busy",   64'(busy_a),   64'd0);
        check("rst.done",   64'(done_a),   64'd0);
        check("rst.counts", 64'(counts_a), 64'd0);
        check("rst.pass",   64'(pass_a),   64'd0);
        check("rst.ovf",    64'(ovf_a),    64'd0);
        check("rst.busy_b", 64'(busy_b),   64'd0);
        @(negedge clock);
        resetb = 1'b1;
        repeat (3) @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            run_a(vecs[i], $sformatf("vec%0d", i));
        end

        // Second start mid-window must be ignored.
        d0 = n_done_a;
        @(negedge clock);
        window_a = 20'd1000; min_a = 16'd20; max_a = 16'd60; start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        lat = 1;
        while (done_a !== 1'b1 && lat < 1030) begin
            @(negedge clock);
            lat++;
            if (lat == 500) begin
                window_a = 20'd5; min_a = 16'd0; max_a = 16'd0; start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
        end
        check("restart.latency", 64'(lat), 64'd1003);
        check_rng("restart.cnt0", 64'(counts_a[15:0]), 49, 51);
        check_rng("restart.cnt1", 64'(counts_a[31:16]), 24, 26);
        check("restart.pass", 64'(pass_a), 64'(RP));

        // Start held through DONE and the following IDLE cycle: only the IDLE one counts.
        window_a = 20'd0; min_a = 16'd0; max_a = 16'd60; start_a = 1'b1;
        @(negedge clock);
        check("done_start.ignored", 64'(busy_a), 64'd0);
        @(negedge clock);
        check("idle_start.accepted", 64'(busy_a), 64'd1);
        start_a = 1'b0;
        lat = 1;
        while (done_a !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("idle_start.latency", 64'(lat), 64'd3);
        check("idle_start.counts", 64'(counts_a), 64'd0);
        check("idle_start.pass", 64'(pass_a), 64'd3);
        @(negedge clock);
        check("restart.done_count", 64'(n_done_a - d0), 64'd2);

        // Reset in the middle of a window.
        @(negedge clock);
        window_a = 20'd1000; min_a = 16'd20; max_a = 16'd60; start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        repeat (300) @(negedge clock);
        d0 = n_done_a;
        resetb = 1'b0;
        #1;
        check("midrst.busy",   64'(busy_a),   64'd0);
        check("midrst.counts", 64'(counts_a), 64'd0);
        check("midrst.pass",   64'(pass_a),   64'd0);
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        repeat (1010) @(negedge clock);
        check("midrst.no_done", 64'(n_done_a - d0), 64'd0);
        run_a(vecs[0], "post_rst");

        // Narrow counters: saturation, then a short window that stays in range.
        @(negedge clock);
        window_b = 20'd1000; min_b = 4'd0; max_b = 4'd15; start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        lat = 1;
        while (done_b !== 1'b1 && lat < 1030) begin
            @(negedge clock);
            lat++;
        end
        check("sat.latency", 64'(lat), 64'd1003);
        check("sat.counts", 64'(counts_b), 64'hFF);
        check("sat.ovf", 64'(ovf_b), 64'd3);
        check("sat.pass", 64'(pass_b), 64'd0);

        @(negedge clock);
        window_b = 20'd20; start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        lat = 1;
        while (done_b !== 1'b1 && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        check("short_b.latency", 64'(lat), 64'd23);
        check_rng("short_b.cnt0", 64'(counts_b[3:0]), 4, 6);
        check("short_b.ovf", 64'(ovf_b), 64'd0);
        check("short_b.pass", 64'(pass_b), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
